// File: rtl/vid_pattern_gen.sv
// Raster timing generator with four built-in test patterns (bars, ramp, checker, frame ID).
// Every output is registered from the counter state sampled on the same enabled edge.
module vid_pattern_gen #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter bit SYNC_POL   = 1'b1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  i_en,
  input  logic [1:0]            i_pattern,
  output logic                  o_vid_VDE,
  output logic                  o_vid_HSYNC,
  output logic                  o_vid_VSYNC,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  output logic                  o_sof,
  output logic                  o_eol
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Minimum widths keep h_cnt[7:0] and v_cnt[3] addressable with tiny rasters.
  localparam int HW      = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
  localparam int VW      = ($clog2(V_TOTAL) > 4) ? $clog2(V_TOTAL) : 4;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_EOL    = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = 24'hFFFFFF;
      3'd1:    bar_color = 24'hFF00FF;
      3'd2:    bar_color = 24'h00FFFF;
      3'd3:    bar_color = 24'h0000FF;
      3'd4:    bar_color = 24'hFFFF00;
      3'd5:    bar_color = 24'hFF0000;
      3'd6:    bar_color = 24'h00FF00;
      3'd7:    bar_color = 24'h000000;
      default: bar_color = 24'h000000;
    endcase
  endfunction

  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic [BW-1:0]         bar_cnt_q, bar_cnt_d;
  logic [2:0]            bar_idx_q, bar_idx_d;
  logic [7:0]            frame_q, frame_d;
  logic [1:0]            pat_q, pat_d;
  logic                  vde_q, vde_d, hs_q, hs_d, vs_q, vs_d, sof_q, sof_d, eol_q, eol_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic        h_last_s, v_last_s, active_s, sof_pos_s;
  logic [1:0]  pat_s;
  logic [23:0] px_s;

  // Next-state and next-output computation for the raster and pattern generator.
  always_comb begin
    h_last_s  = (h_q == H_LAST);
    v_last_s  = (v_q == V_LAST);
    active_s  = (h_q < H_ACT_L) && (v_q < V_ACT_L);
    sof_pos_s = (h_q == '0) && (v_q == '0);
    // The pattern latched at frame start already applies to pixel (0,0).
    pat_s     = sof_pos_s ? i_pattern : pat_q;

    case (pat_s)
      2'd0:    px_s = bar_color(bar_idx_q);
      2'd1:    px_s = {3{h_q[7:0]}};
      2'd2:    px_s = {24{h_q[3] ^ v_q[3]}};
      2'd3:    px_s = {frame_q, ~frame_q, 8'h00};
      default: px_s = 24'h000000;
    endcase

    h_d       = h_q;
    v_d       = v_q;
    frame_d   = frame_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    pat_d     = pat_q;
    vde_d     = 1'b0;
    sof_d     = 1'b0;
    eol_d     = 1'b0;
    data_d    = '0;
    hs_d      = hs_q;
    vs_d      = vs_q;

    if (i_en) begin
      if (h_last_s) begin
        h_d = '0;
        if (v_last_s) begin
          v_d     = '0;
          frame_d = frame_q + 8'd1;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end

      if (sof_pos_s) begin
        pat_d = i_pattern;
      end else begin
        pat_d = pat_q;
      end

      if (h_last_s) begin
        bar_cnt_d = '0;
        bar_idx_d = 3'd0;
      end else if (h_q < H_ACT_L) begin
        if (bar_cnt_q == BAR_LAST) begin
          bar_cnt_d = '0;
          bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_cnt_d = bar_cnt_q + BW'(1);
        end
      end else begin
        bar_cnt_d = bar_cnt_q;
      end

      vde_d  = active_s;
      sof_d  = sof_pos_s;
      eol_d  = (h_q == H_EOL) && (v_q < V_ACT_L);
      data_d = active_s ? DATA_WIDTH'(px_s) : '0;
      hs_d   = ((h_q >= H_SYNC_S) && (h_q < H_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
      vs_d   = ((v_q >= V_SYNC_S) && (v_q < V_SYNC_E)) ? SYNC_POL : ~SYNC_POL;
    end else begin
      h_d = h_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      h_q       <= '0;
      v_q       <= '0;
      frame_q   <= 8'd0;
      bar_cnt_q <= '0;
      bar_idx_q <= 3'd0;
      pat_q     <= 2'd0;
      vde_q     <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      data_q    <= '0;
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      frame_q   <= frame_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      vde_q     <= vde_d;
      sof_q     <= sof_d;
      eol_q     <= eol_d;
      data_q    <= data_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  assign o_vid_VDE   = vde_q;
  assign o_vid_HSYNC = hs_q;
  assign o_vid_VSYNC = vs_q;
  assign o_vid_data  = data_q;
  assign o_sof       = sof_q;
  assign o_eol       = eol_q;

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen on a 24x8 raster (16x4 active).
// Expected outputs come from the bench's own raster position and pattern tables.
module tb_vid_pattern_gen;

  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFF00FF, 24'h00FFFF, 24'h0000FF,
                                      24'hFFFF00, 24'hFF0000, 24'h00FF00, 24'h000000};

  logic        clk;
  logic        n_rst;
  logic        i_en;
  logic [1:0]  i_pattern;
  logic        vde, hs, vs, sof, eol;
  logic [23:0] data;

  int checks = 0;
  int errors = 0;
  int bh = 0, bl = 0, bf = 0;
  int cur_pat = 0, pat_sel = 0;
  int tcnt = 0, sof_t = 0, prev_sof_t = 0;
  int vde_fr = 0, eol_fr = 0;

  vid_pattern_gen #(
    .DATA_WIDTH(24), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b1)
  ) dut (
    .clk(clk), .n_rst(n_rst), .i_en(i_en), .i_pattern(i_pattern),
    .o_vid_VDE(vde), .o_vid_HSYNC(hs), .o_vid_VSYNC(vs),
    .o_vid_data(data), .o_sof(sof), .o_eol(eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (h=%0d line=%0d frame=%0d)", tag, obs, exp, bh, bl, bf);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    tcnt++;
  endtask

  task automatic set_pat(input int p);
    pat_sel   = p;
    i_pattern = 2'(p);
  endtask

  function automatic logic [23:0] exp_data(input int pat, input int h, input int l, input int f);
    logic [7:0] hb;
    logic [7:0] fb;
    hb = 8'(h);
    fb = 8'(f);
    case (pat)
      0:       exp_data = BARS[h / 2];
      1:       exp_data = {hb, hb, hb};
      2:       exp_data = ((((h / 8) % 2) ^ ((l / 8) % 2)) != 0) ? 24'hFFFFFF : 24'h000000;
      3:       exp_data = {fb, ~fb, 8'h00};
      default: exp_data = 24'h000000;
    endcase
  endfunction

  task automatic check_reset_vals;
    check("rst_vde",   32'(vde),  32'd0);
    check("rst_hsync", 32'(hs),   32'd0);
    check("rst_vsync", 32'(vs),   32'd0);
    check("rst_sof",   32'(sof),  32'd0);
    check("rst_eol",   32'(eol),  32'd0);
    check("rst_data",  32'(data), 32'd0);
  endtask

  // One enabled clock: compare every output against the expected pixel, then advance the position.
  task automatic step;
    logic        act;
    logic [23:0] ed;
    tick;
    if (bh == 0 && bl == 0) begin
      cur_pat    = pat_sel;
      prev_sof_t = sof_t;
      sof_t      = tcnt;
    end
    act = (bh < 16) && (bl < 4);
    ed  = act ? exp_data(cur_pat, bh, bl, bf % 256) : 24'h000000;
    check("vde",   32'(vde),  32'(act));
    check("hsync", 32'(hs),   32'((bh >= 18) && (bh < 20)));
    check("vsync", 32'(vs),   32'(bl == 5));
    check("sof",   32'(sof),  32'((bh == 0) && (bl == 0)));
    check("eol",   32'(eol),  32'((bh == 15) && (bl < 4)));
    check("data",  32'(data), 32'(ed));
    vde_fr += 32'(vde);
    eol_fr += 32'(eol);
    bh++;
    if (bh == 24) begin
      bh = 0;
      bl++;
      if (bl == 8) begin
        bl = 0;
        bf++;
        check("vde_per_frame", 32'(vde_fr), 32'd64);
        check("eol_per_frame", 32'(eol_fr), 32'd4);
        vde_fr = 0;
        eol_fr = 0;
      end
    end
  endtask

  initial begin
    n_rst = 1'b0;
    i_en  = 1'b0;
    set_pat(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();

    // Release reset away from the edge; the next edge presents pixel (0,0).
    #2;
    n_rst = 1'b1;
    i_en  = 1'b1;

    // Frames 0-2: timing plus colour bars.
    repeat (576) step();

    // Frame 3: switch to ramp mid-frame, bars continue.
    repeat (50) step();
    set_pat(1);
    repeat (142) step();

    // Frame 4: ramp.
    repeat (6) step();
    check("ramp_px5", 32'(data), 32'h050505);
    repeat (40) step();
    set_pat(2);
    repeat (146) step();

    // Frame 5: checker.
    step();
    check("chk_0_0", 32'(data), 32'h000000);
    repeat (8) step();
    check("chk_8_0", 32'(data), 32'hFFFFFF);
    repeat (20) step();
    set_pat(3);
    repeat (163) step();

    // Frames 6-256: frame ID through the 255->0 wrap.
    repeat (251 * 192) step();

    // Frame 257: frame_cnt back to 1.
    step();
    check("fid_wrap", 32'(data), 32'h01FE00);
    repeat (50) step();
    set_pat(0);
    repeat (141) step();

    // Frame 258: pause at pixel (5,2).
    repeat (54) step();
    check("pause_at_vde", 32'(vde), 32'd1);
    i_en = 1'b0;
    repeat (10) begin
      tick();
      check("pause_vde",   32'(vde),  32'd0);
      check("pause_data",  32'(data), 32'd0);
      check("pause_sof",   32'(sof),  32'd0);
      check("pause_eol",   32'(eol),  32'd0);
      check("pause_hsync", 32'(hs),   32'd0);
      check("pause_vsync", 32'(vs),   32'd0);
    end
    i_en = 1'b1;
    step();
    check("resume_px6", 32'(data), 32'h0000FF);
    repeat (137) step();

    // Frame 259: length check, then reset at pixel (7,1).
    step();
    check("frame_len", 32'(sof_t - prev_sof_t), 32'd202);
    repeat (31) step();
    check("pre_rst_vde",  32'(vde),  32'd1);
    check("pre_rst_data", 32'(data), 32'h0000FF);
    #1;
    n_rst = 1'b0;
    #1;
    check_reset_vals();
    #3;
    n_rst  = 1'b1;
    bh     = 0;
    bl     = 0;
    bf     = 0;
    vde_fr = 0;
    eol_fr = 0;
    step();
    check("post_rst_sof",  32'(sof),  32'd1);
    check("post_rst_data", 32'(data), 32'hFFFFFF);
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vid_pattern_gen.md
# vid_pattern_gen

Video source that drives the kernel filter path from the upstream side. It generates raster timing (VDE, HSYNC, VSYNC) and packed {R,B,G} pixel data for one of four built-in test patterns. It replaces or bypasses the HDMI input during bring-up and regression, so multi-pixel effects can be checked against a known, deterministic stream. All outputs are registered.

## Interface
- DATA_WIDTH, 24: pixel width, packed {R[23:16], B[15:8], G[7:0]}
- H_ACTIVE, 1920: active pixels per line; must be a multiple of 8
- H_FP, 88 / H_SYNC, 44 / H_BP, 148: horizontal front porch, sync, back porch (clocks)
- V_ACTIVE, 1080: active lines per frame
- V_FP, 4 / V_SYNC, 5 / V_BP, 36: vertical front porch, sync, back porch (lines)
- SYNC_POL, 1: asserted level of HSYNC/VSYNC (1 = active-high)

Ports:
- clk  in  1  pixel clock
- n_rst  in  1  reset, asynchronous, active-low
- i_en  in  1  advance enable; low pauses the raster
- i_pattern  in  2  pattern select, sampled at frame start
- o_vid_VDE  out  1  active-video flag
- o_vid_HSYNC  out  1  horizontal sync
- o_vid_VSYNC  out  1  vertical sync
- o_vid_data  out  DATA_WIDTH  pixel data; 0 when VDE is low
- o_sof  out  1  one-cycle pulse on pixel (0,0)
- o_eol  out  1  one-cycle pulse on the last active pixel of each active line

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0.
- v_cnt increments when h_cnt wraps, runs 0..V_TOTAL-1 and wraps to 0.
- Counters advance only on cycles with i_en=1.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- HSYNC is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) on every line.
- VSYNC is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), for whole lines.
- Pattern register loads i_pattern when (h_cnt,v_cnt)=(0,0) and i_en=1. A pattern change mid-frame is ignored until the next frame.
- 8-bit frame_cnt increments on each v_cnt wrap and wraps 255->0.
- Pattern 0, colour bars: eight bars of H_ACTIVE/8 pixels each, tracked by a bar-width counter and a 3-bit bar index (no divider). Values in order:
  - white 0xFFFFFF
  - yellow 0xFF00FF
  - cyan 0x00FFFF
  - green 0x0000FF
  - magenta 0xFFFF00
  - red 0xFF0000
  - blue 0x00FF00
  - black 0x000000
- Pattern 1, ramp: R=B=G=h_cnt[7:0].
- Pattern 2, checker: all channels 0xFF when h_cnt[3]^v_cnt[3] is 1, else 0x00.
- Pattern 3, frame ID: R=frame_cnt, B=~frame_cnt, G=0x00.
- i_en=0: counters, bar state and frame_cnt hold. VDE, o_sof and o_eol are forced 0, data is 0, syncs hold their value. The raster resumes from the held position when i_en returns high.

## Timing
- Reset values: VDE=0, o_sof=0, o_eol=0, data=0, HSYNC=VSYNC=~SYNC_POL. Counters, bar state and frame_cnt reset to 0; pattern register resets to 0.
- Latency: all outputs are registered and reflect the counter state from the same edge. The first rising edge with i_en=1 after reset release presents pixel (0,0): VDE=1 and o_sof=1.
- o_sof coincides with VDE on (0,0) only. o_eol coincides with VDE on h_cnt=H_ACTIVE-1 for v_cnt < V_ACTIVE.
- Reset asserted mid-frame: all outputs go to reset values immediately (asynchronous). After release the raster restarts at (0,0).
- VDE is high for exactly H_ACTIVE×V_ACTIVE enabled cycles per frame. Data is 0 on every cycle where VDE=0.

## Test plan
Use small parameters for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=2, H_BP=4 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2 (V_TOTAL=8).
- Timing, i_en=1, 3 frames: VDE high exactly 64 cycles per frame; o_sof every 192 cycles; HSYNC high on h_cnt 18-19 on all 8 lines; VSYNC high for cycles 120-143 of each frame; o_eol high 4 times per frame.
- Colour bars, pattern 0: active pixels 0-1 = 0xFFFFFF, 2-3 = 0xFF00FF, …, 14-15 = 0x000000 on every active line; blanking data = 0.
- Pattern switch: i_pattern changed 0->1 mid-frame -> rest of frame is still bars; next frame pixel 5 = 0x050505.
- Checker and frame ID: pattern 2 -> pixel (8,0) = 0xFFFFFF, (0,0) = 0. Pattern 3 held for 257 frames -> frame ID wraps: R=0x01, B=0xFE on frame 257 (frame_cnt=0x01).
- Pause: i_en low for 10 cycles at pixel (5,2) -> VDE=0 and data=0 during the pause; resume outputs pixel (6,2); frame length = 202 cycles.
- Reset mid-line at pixel (7,1): outputs go to reset values immediately; after release, first enabled edge gives o_sof=1 with pattern 0 data 0xFFFFFF.
